// File: rtl/block_csel_adder_seq_if.sv
// Request/result bundle for block_csel_adder_seq.
// The ovf signal exists only when ADDER_OVF_EN is defined.
interface block_csel_adder_seq_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;

    modport master (
        output valid_in, a, b, cin, sub, ready_in,
        input  ready_out, valid_out, s, cout, ovf
    );

    modport slave (
        input  valid_in, a, b, cin, sub, ready_in,
        output ready_out, valid_out, s, cout, ovf
    );
`else
    modport master (
        output valid_in, a, b, cin, sub, ready_in,
        input  ready_out, valid_out, s, cout
    );

    modport slave (
        input  valid_in, a, b, cin, sub, ready_in,
        output ready_out, valid_out, s, cout
    );
`endif
endinterface

// File: rtl/block_csel_adder_seq.sv
// Iterative carry-select adder/subtractor, one BLOCK-bit slice per clock.
// Define ADDER_OVF_EN to add the signed-overflow output ovf.
module block_csel_adder_seq #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input logic                   clock,
    input logic                   reset_n,
    block_csel_adder_seq_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic [BLOCK-1:0] w_ak;
    logic [BLOCK-1:0] w_bk;
    logic [BLOCK:0]   w_sum0;
    logic [BLOCK:0]   w_sum1;
    logic [BLOCK:0]   w_sel;
    logic             w_last;

    assign w_ak   = r_opa[r_cnt*BLOCK +: BLOCK];
    assign w_bk   = r_opb[r_cnt*BLOCK +: BLOCK];
    // Both carry hypotheses are formed every cycle; the registered carry picks one.
    assign w_sum0 = {1'b0, w_ak} + {1'b0, w_bk};
    assign w_sum1 = {1'b0, w_ak} + {1'b0, w_bk} + {{BLOCK{1'b0}}, 1'b1};
    assign w_sel  = r_carry ? w_sum1 : w_sum0;
    assign w_last = (r_cnt == CW'(NBLK - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.valid_in) w_next = S_RUN;
            S_RUN:   if (w_last)       w_next = S_DONE;
            S_DONE:  if (bus.ready_in) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE && bus.valid_in) begin
            r_opa   <= bus.a;
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_s[r_cnt*BLOCK +: BLOCK] <= w_sel[BLOCK-1:0];
            r_carry <= w_sel[BLOCK];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_cout <= w_sel[BLOCK];
        end
    end

    assign bus.ready_out = (r_state == S_IDLE);
    assign bus.valid_out = (r_state == S_DONE);
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;

`ifdef ADDER_OVF_EN
    logic r_ovf;
    logic w_cmsb;

    // Carry into the MSB recovered from the sum bit and the operand bits.
    assign w_cmsb = w_ak[BLOCK-1] ^ w_bk[BLOCK-1] ^ w_sel[BLOCK-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && bus.valid_in) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_ovf <= w_cmsb ^ w_sel[BLOCK];
        end
    end

    assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_block_csel_adder_seq.sv
// Directed-vector bench for block_csel_adder_seq (32/4 and 8/8 instances).
// ovf checks compile in when ADDER_OVF_EN is defined.
module tb_block_csel_adder_seq;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    block_csel_adder_seq_if #(.WIDTH(32)) bus ();
    block_csel_adder_seq_if #(.WIDTH(8))  bus8 ();

    block_csel_adder_seq #(.WIDTH(32), .BLOCK(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    block_csel_adder_seq #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    always #5 clock = ~clock;

    // Drives one request, scrambles the inputs after capture, waits for valid_out.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, output int lat);
        @(negedge clock);
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        bus.valid_in = 1'b1;
        @(posedge clock);
        #1;
        bus.valid_in = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        bus.cin = ~cin;
        bus.sub = ~sub;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.valid_out) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.ready_out !== 1'b1) begin
            bad++; $display("FAIL rst_ready got=%b exp=1", bus.ready_out);
        end
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid_out);
        end
        total++;
        if (bus.s !== 32'h0) begin
            bad++; $display("FAIL rst_s got=%h exp=0", bus.s);
        end
        total++;
        if (bus.cout !== 1'b0) begin
            bad++; $display("FAIL rst_cout got=%b exp=0", bus.cout);
        end
        total++;
        if (bus8.valid_out !== 1'b0) begin
            bad++; $display("FAIL rst_valid8 got=%b exp=0", bus8.valid_out);
        end
`ifdef ADDER_OVF_EN
        total++;
        if (bus.ovf !== 1'b0) begin
            bad++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_add_wrap();
        int lat;
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        total++;
        if (lat != 8) begin
            bad++; $display("FAIL wrap_lat got=%0d exp=8", lat);
        end
        total++;
        if (bus.s !== 32'h0) begin
            bad++; $display("FAIL wrap_s got=%h exp=00000000", bus.s);
        end
        total++;
        if (bus.cout !== 1'b1) begin
            bad++; $display("FAIL wrap_cout got=%b exp=1", bus.cout);
        end
        @(posedge clock);
        #1;
        total++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            bad++;
            $display("FAIL wrap_hs got valid=%b ready=%b exp valid=0 ready=1",
                     bus.valid_out, bus.ready_out);
        end
    endtask

    task automatic test_sub();
        int lat;
        issue(32'd5, 32'd7, 1'b1, 1'b1, lat);
        total++;
        if (bus.s !== 32'hFFFF_FFFE || bus.cout !== 1'b0) begin
            bad++;
            $display("FAIL sub_neg got s=%h c=%b exp s=fffffffe c=0", bus.s, bus.cout);
        end
        @(posedge clock);
        #1;
        issue(32'd7, 32'd5, 1'b0, 1'b1, lat);
        total++;
        if (bus.s !== 32'h2 || bus.cout !== 1'b1) begin
            bad++;
            $display("FAIL sub_pos got s=%h c=%b exp s=00000002 c=1", bus.s, bus.cout);
        end
        total++;
        if (lat != 8) begin
            bad++; $display("FAIL sub_lat got=%0d exp=8", lat);
        end
        @(posedge clock);
        #1;
    endtask

`ifdef ADDER_OVF_EN
    task automatic test_ovf();
        int lat;
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        total++;
        if (bus.s !== 32'h8000_0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pos got s=%h c=%b o=%b exp s=80000000 c=0 o=1",
                     bus.s, bus.cout, bus.ovf);
        end
        @(posedge clock);
        #1;
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat);
        total++;
        if (bus.s !== 32'h0 || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_neg got s=%h c=%b o=%b exp s=00000000 c=1 o=1",
                     bus.s, bus.cout, bus.ovf);
        end
        @(posedge clock);
        #1;
        issue(32'h1, 32'h1, 1'b0, 1'b0, lat);
        total++;
        if (bus.s !== 32'h2 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_none got s=%h o=%b exp s=00000002 o=0", bus.s, bus.ovf);
        end
        @(posedge clock);
        #1;
    endtask
`endif

    task automatic test_backpressure();
        int lat;
        bus.ready_in = 1'b0;
        issue(32'h10, 32'h20, 1'b0, 1'b0, lat);
        total++;
        if (lat != 8 || bus.s !== 32'h30 || bus.cout !== 1'b0) begin
            bad++;
            $display("FAIL bp_first got lat=%0d s=%h c=%b exp lat=8 s=00000030 c=0",
                     lat, bus.s, bus.cout);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            bus.valid_in = 1'b1;
            bus.a = 32'h1;
            bus.b = 32'h1;
            @(posedge clock);
            #1;
            total++;
            if (bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0 ||
                bus.s !== 32'h30 || bus.cout !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b r=%b s=%h c=%b exp v=1 r=0 s=00000030 c=0",
                         k, bus.valid_out, bus.ready_out, bus.s, bus.cout);
            end
        end
        @(negedge clock);
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got v=%b r=%b exp v=0 r=1",
                     bus.valid_out, bus.ready_out);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        @(negedge clock);
        bus.a = 32'h1234_5678;
        bus.b = 32'h1111_1111;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.valid_in = 1'b1;
        @(posedge clock);
        #1;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0 ||
            bus.s !== 32'h0 || bus.cout !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst got r=%b v=%b s=%h c=%b exp r=1 v=0 s=00000000 c=0",
                     bus.ready_out, bus.valid_out, bus.s, bus.cout);
        end
        @(negedge clock);
        reset_n = 1'b1;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
        total++;
        if (lat != 8 || bus.s !== 32'h2345_6789 || bus.cout !== 1'b0) begin
            bad++;
            $display("FAIL mid_fresh got lat=%0d s=%h c=%b exp lat=8 s=23456789 c=0",
                     lat, bus.s, bus.cout);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_narrow();
        int lat;
        @(negedge clock);
        bus8.a = 8'hF0;
        bus8.b = 8'h20;
        bus8.cin = 1'b1;
        bus8.sub = 1'b0;
        bus8.valid_in = 1'b1;
        @(posedge clock);
        #1;
        bus8.valid_in = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (bus8.valid_out) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat != 1) begin
            bad++; $display("FAIL n8_lat got=%0d exp=1", lat);
        end
        total++;
        if (bus8.s !== 8'h11 || bus8.cout !== 1'b1) begin
            bad++;
            $display("FAIL n8_sum got s=%h c=%b exp s=11 c=1", bus8.s, bus8.cout);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.ready_in  = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus8.valid_in = 1'b0;
        bus8.ready_in = 1'b1;
        bus8.a        = '0;
        bus8.b        = '0;
        bus8.cin      = 1'b0;
        bus8.sub      = 1'b0;
        test_reset();
        test_add_wrap();
        test_sub();
`ifdef ADDER_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_mid_reset();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
